// File: rtl/dcache_pkg.sv
// Shared types and geometry for the L1 data cache controller.
// Contents:
//   ADDR_W/INDEX_W/LINE_WORDS  cache geometry (byte address, line index bits, words per line)
//   OFFSET_W/TAG_W/LINE_ADDR_W derived field widths of a byte address
//   state_t                    controller FSM states
//   store_entry_t              one buffered store {addr, data, be}
//   merge_bytes                byte-enable merge of a store into an existing word
package dcache_pkg;

  localparam int ADDR_W      = 32;
  localparam int INDEX_W     = 8;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_W    = $clog2(LINE_WORDS);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINE_ADDR_W = TAG_W + INDEX_W;
  localparam int NUM_LINES   = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    REFILL_REQ = 2'd2,
    REFILL     = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } store_entry_t;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Word-wide external memory port of the data cache.
// Signals:
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  request from the cache (held until mem_ready)
//   mem_ready                                 request accepted this cycle
//   mem_rvalid/mem_rdata                      read beats, LINE_WORDS per line read, word 0 first
// Modports: master = cache side, slave = memory side.
interface dcache_mem_if;
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/dcache_store_buffer.sv
// One-entry store buffer between the cache and the memory write port.
// Ports:
//   clk, rst            core clock, synchronous active-low reset
//   push, push_entry    capture a store (allowed while full if pop is also high)
//   pop                 entry accepted by memory this cycle
//   full, entry         occupancy flag and buffered store
module dcache_store_buffer
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  store_entry_t push_entry,
  input  logic         pop,
  output logic         full,
  output store_entry_t entry
);

  logic         full_q, full_d;
  store_entry_t entry_q, entry_d;

  // Next occupancy: a push in the same cycle as a pop reuses the freed slot.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (push) begin
      full_d  = 1'b1;
      entry_d = push_entry;
    end else if (pop) begin
      full_d  = 1'b0;
    end else begin
      full_d  = full_q;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full  = full_q;
  assign entry = entry_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate L1 data cache for the M stage.
// Ports:
//   clk, rst                          core clock, synchronous active-low reset
//   mem_re_m, mem_we_m                M-stage load / store (mutually exclusive)
//   addr_m, wdata_m, be_m             byte address ([1:0] ignored), store data, byte enables
//   rdata_m                           load data (full word)
//   cache_data_valid                  M-stage access completes this cycle; 1 with no access
//   mem                               external memory port (dcache_mem_if.master)
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_re_m,
  input  logic              mem_we_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [31:0]       wdata_m,
  input  logic [3:0]        be_m,
  output logic [31:0]       rdata_m,
  output logic              cache_data_valid,
  dcache_mem_if.master      mem
);

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  // Tag and data arrays are async-read RAM; only the valid bits need reset.
  logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
  logic [31:0]          data_ram [NUM_LINES][LINE_WORDS];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  state_t                 state_q, state_d;
  logic [OFFSET_W-1:0]    cnt_q, cnt_d;
  logic [LINE_ADDR_W-1:0] fill_line_q, fill_line_d;

  logic [INDEX_W-1:0]  idx, fill_idx, ram_idx;
  logic [OFFSET_W-1:0] off, ram_off;
  logic [TAG_W-1:0]    tag, fill_tag;
  logic [31:0]         line_word, ram_wdata;
  logic                hit, ram_we, tag_we;
  logic                sb_full, sb_push, sb_pop, drain_active;
  store_entry_t        sb_entry, sb_in;
  logic                unused_addr_bits;

  assign idx       = addr_m[OFFSET_W+2 +: INDEX_W];
  assign off       = addr_m[2 +: OFFSET_W];
  assign tag       = addr_m[ADDR_W-1 -: TAG_W];
  assign fill_idx  = fill_line_q[INDEX_W-1:0];
  assign fill_tag  = fill_line_q[LINE_ADDR_W-1 -: TAG_W];
  assign line_word = data_ram[idx][off];
  assign hit       = valid_q[idx] && (tag_ram[idx] == tag);
  assign rdata_m   = line_word;
  assign sb_in     = '{addr: addr_m, data: wdata_m, be: be_m};

  // Word alignment is handled upstream, so the low address bits carry no information.
  assign unused_addr_bits = ^{addr_m[1:0], sb_entry.addr[1:0]};

  // The buffer owns the write port except while a line read is outstanding.
  assign drain_active = sb_full && (state_q != REFILL_REQ) && (state_q != REFILL);
  assign sb_pop       = drain_active && mem.mem_ready;

  dcache_store_buffer u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_entry (sb_in),
    .pop        (sb_pop),
    .full       (sb_full),
    .entry      (sb_entry)
  );

  // FSM next state, completion flag and array write controls.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    fill_line_d      = fill_line_q;
    valid_d          = valid_q;
    cache_data_valid = !(mem_re_m || mem_we_m);
    sb_push          = 1'b0;
    ram_we           = 1'b0;
    ram_idx          = idx;
    ram_off          = off;
    ram_wdata        = merge_bytes(line_word, wdata_m, be_m);
    tag_we           = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_re_m) begin
          if (hit) begin
            cache_data_valid = 1'b1;
          end else begin
            // Latch the line so the refill completes even if the load goes away.
            fill_line_d = addr_m[ADDR_W-1 -: LINE_ADDR_W];
            state_d     = sb_full ? DRAIN : REFILL_REQ;
          end
        end else if (mem_we_m) begin
          // A full buffer frees its slot in the same cycle memory accepts it.
          if (!sb_full || sb_pop) begin
            cache_data_valid = 1'b1;
            sb_push          = 1'b1;
            ram_we           = hit;
          end else begin
            cache_data_valid = 1'b0;
          end
        end else begin
          cache_data_valid = 1'b1;
        end
      end
      DRAIN: begin
        // The pending store must reach memory before the line is read back.
        if (!sb_full) begin
          state_d = REFILL_REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      REFILL_REQ: begin
        if (mem.mem_ready) begin
          state_d = REFILL;
          cnt_d   = '0;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      REFILL: begin
        if (mem.mem_rvalid) begin
          ram_we    = 1'b1;
          ram_idx   = fill_idx;
          ram_off   = cnt_q;
          ram_wdata = mem.mem_rdata;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            tag_we            = 1'b1;
            valid_d[fill_idx] = 1'b1;
            state_d           = IDLE;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port mux: line read in REFILL_REQ, otherwise drain the store buffer.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 32'h0000_0000;
    mem.mem_be    = 4'b0000;
    if (state_q == REFILL_REQ) begin
      mem.mem_req  = 1'b1;
      mem.mem_addr = {fill_line_q, {(OFFSET_W + 2){1'b0}}};
    end else if (drain_active) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = 1'b1;
      mem.mem_addr  = {sb_entry.addr[ADDR_W-1:2], 2'b00};
      mem.mem_wdata = sb_entry.data;
      mem.mem_be    = sb_entry.be;
    end else begin
      mem.mem_req = 1'b0;
    end
  end

  // Control state registers; reset invalidates every line at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_line_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_line_q <= fill_line_d;
      valid_q     <= valid_d;
    end
  end

  // Array writes: refill beats, store-hit byte merges and the tag on the last beat.
  always_ff @(posedge clk) begin
    if (rst && ram_we) begin
      data_ram[ram_idx][ram_off] <= ram_wdata;
    end
    if (rst && tag_we) begin
      tag_ram[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the stimulus pushes expected completions and
// expected memory transactions; two monitors pop and compare them as they occur.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_re_m, mem_we_m;
  logic [ADDR_W-1:0] addr_m;
  logic [31:0]       wdata_m, rdata_m;
  logic [3:0]        be_m;
  logic              cache_data_valid;
  logic              ready_en;

  dcache_mem_if mif();

  dcache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .mem_re_m         (mem_re_m),
    .mem_we_m         (mem_we_m),
    .addr_m           (addr_m),
    .wdata_m          (wdata_m),
    .be_m             (be_m),
    .rdata_m          (rdata_m),
    .cache_data_valid (cache_data_valid),
    .mem              (mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int op_id = 0;

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
    logic        zero_lat;
    logic [31:0] beats;
    logic [7:0]  id;
  } exp_op_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_mem_t;

  exp_op_t  op_q[$];
  exp_mem_t mem_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_op(input logic ld, input logic [31:0] d, input logic zl, input int beats);
    exp_op_t e;
    e.is_load  = ld;
    e.rdata    = d;
    e.zero_lat = zl;
    e.beats    = beats;
    e.id       = 8'(op_id);
    op_id++;
    op_q.push_back(e);
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_mem_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.be    = be;
    mem_q.push_back(e);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [int unsigned];
  int          mdl_beats = 0;
  bit          mdl_rd_acc = 1'b0;
  bit          mdl_wr_pend = 1'b0;
  logic [31:0] mdl_base, mdl_wa, mdl_wd;
  logic [3:0]  mdl_wb;
  bit          mdl_rst;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin : mem_model
    logic [31:0] w;
    mif.mem_ready  = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      mdl_rst = rst;
      #1;
      mif.mem_ready  = 1'b0;
      mif.mem_rvalid = 1'b0;
      if (!mdl_rst) begin
        mdl_beats   = 0;
        mdl_rd_acc  = 1'b0;
        mdl_wr_pend = 1'b0;
      end else begin
        if (mdl_wr_pend) begin
          w = mem_rd(mdl_wa);
          for (int b = 0; b < 4; b++) if (mdl_wb[b]) w[8*b +: 8] = mdl_wd[8*b +: 8];
          mem_arr[mdl_wa] = w;
          mdl_wr_pend = 1'b0;
        end
        if (mdl_rd_acc) begin
          mdl_beats  = LINE_WORDS;
          mdl_rd_acc = 1'b0;
        end
        if (mdl_beats > 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = mem_rd(mdl_base + 32'(4 * (LINE_WORDS - mdl_beats)));
          mdl_beats--;
        end else if (mif.mem_req && ready_en) begin
          mif.mem_ready = 1'b1;
          if (mif.mem_we) begin
            mdl_wr_pend = 1'b1;
            mdl_wa      = mif.mem_addr;
            mdl_wd      = mif.mem_wdata;
            mdl_wb      = mif.mem_be;
          end else begin
            mdl_rd_acc = 1'b1;
            mdl_base   = mif.mem_addr;
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int op_cycles = 0;
  int op_beats  = 0;

  always @(negedge clk) begin : op_monitor
    exp_op_t e;
    if (rst && (mem_re_m || mem_we_m)) begin
      if (cache_data_valid) begin
        if (op_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion: got addr 0x%08h want no completion", addr_m);
        end else begin
          e = op_q.pop_front();
          if (e.is_load) check($sformatf("op%0d_rdata", e.id), rdata_m, e.rdata);
          check($sformatf("op%0d_zero_latency", e.id), {31'b0, op_cycles == 0}, {31'b0, e.zero_lat});
          check($sformatf("op%0d_beats", e.id), op_beats, e.beats);
        end
        op_cycles = 0;
        op_beats  = 0;
      end else begin
        op_cycles++;
        if (mif.mem_rvalid) op_beats++;
      end
    end else begin
      op_cycles = 0;
      op_beats  = 0;
    end
  end

  always @(negedge clk) begin : mem_monitor
    exp_mem_t e;
    if (mif.mem_req && mif.mem_ready) begin
      if (mem_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mem_txn: got we=%0b addr 0x%08h want none", mif.mem_we, mif.mem_addr);
      end else begin
        e = mem_q.pop_front();
        check("mem_we", {31'b0, mif.mem_we}, {31'b0, e.we});
        check("mem_addr", mif.mem_addr, e.addr);
        if (e.we) begin
          check("mem_wdata", mif.mem_wdata, e.wdata);
          check("mem_be", {28'b0, mif.mem_be}, {28'b0, e.be});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_load(input logic [31:0] a);
    @(posedge clk);
    #1;
    mem_re_m = 1'b1;
    mem_we_m = 1'b0;
    addr_m   = a;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk);
    #1;
    mem_re_m = 1'b0;
    mem_we_m = 1'b1;
    addr_m   = a;
    wdata_m  = d;
    be_m     = be;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    mem_re_m = 1'b0;
    mem_we_m = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (cache_data_valid) break;
      n++;
    end
    check({name, "_completes"}, {31'b0, n < 200}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int guard;
    mem_re_m = 1'b0;
    mem_we_m = 1'b0;
    addr_m   = 32'h0;
    wdata_m  = 32'h0;
    be_m     = 4'b0000;
    ready_en = 1'b1;
    mem_arr[32'h100] = 32'h0000_0011;
    mem_arr[32'h104] = 32'h0000_0022;
    mem_arr[32'h108] = 32'h0000_0033;
    mem_arr[32'h10C] = 32'h0000_0044;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, cache_data_valid}, 32'd1);
    check("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mif.mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // T1: cold load miss, line read at 0x100
    exp_mem(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_op(1'b1, 32'h0000_0011, 1'b0, 4);
    drive_load(32'h100);
    wait_done("t1_load_miss");

    // T2: hits in the refilled line, no memory traffic
    exp_op(1'b1, 32'h0000_0022, 1'b1, 0);
    drive_load(32'h104);
    wait_done("t2_hit_104");
    exp_op(1'b1, 32'h0000_0044, 1'b1, 0);
    drive_load(32'h10C);
    wait_done("t2_hit_10c");

    // T3: store hit with partial byte enables, then load merged word
    exp_mem(1'b1, 32'h108, 32'hAABB_CCDD, 4'b0011);
    exp_op(1'b0, 32'h0, 1'b1, 0);
    drive_store(32'h108, 32'hAABB_CCDD, 4'b0011);
    wait_done("t3_store");
    exp_op(1'b1, 32'h0000_CCDD, 1'b1, 0);
    drive_load(32'h108);
    wait_done("t3_load_merged");
    go_idle();
    repeat (3) @(negedge clk);

    // T4: back-to-back stores with memory stalled
    ready_en = 1'b0;
    exp_mem(1'b1, 32'h100, 32'h7700_0000, 4'b1000);
    exp_op(1'b0, 32'h0, 1'b1, 0);
    drive_store(32'h100, 32'h7700_0000, 4'b1000);
    wait_done("t4_store_a");
    exp_mem(1'b1, 32'h104, 32'h0000_0099, 4'b0001);
    exp_op(1'b0, 32'h0, 1'b0, 0);
    drive_store(32'h104, 32'h0000_0099, 4'b0001);
    repeat (4) @(negedge clk);
    ready_en = 1'b1;
    wait_done("t4_store_b");
    exp_op(1'b1, 32'h7700_0011, 1'b1, 0);
    drive_load(32'h100);
    wait_done("t4_load_100");
    exp_op(1'b1, 32'h0000_0099, 1'b1, 0);
    drive_load(32'h104);
    wait_done("t4_load_104");
    go_idle();
    repeat (3) @(negedge clk);

    // T5: store miss pending in buffer, then load of same address drains first
    ready_en = 1'b0;
    exp_mem(1'b1, 32'h2000, 32'hCAFE_F00D, 4'b1111);
    exp_op(1'b0, 32'h0, 1'b1, 0);
    drive_store(32'h2000, 32'hCAFE_F00D, 4'b1111);
    wait_done("t5_store_miss");
    exp_mem(1'b0, 32'h2000, 32'h0, 4'b0000);
    exp_op(1'b1, 32'hCAFE_F00D, 1'b0, 4);
    drive_load(32'h2000);
    repeat (4) @(negedge clk);
    ready_en = 1'b1;
    wait_done("t5_load_after_drain");
    exp_op(1'b1, 32'h5A5A_2004, 1'b1, 0);
    drive_load(32'h2004);
    wait_done("t5_hit_2004");

    // T6: reset during refill beat 2
    exp_mem(1'b0, 32'h300, 32'h0, 4'b0000);
    drive_load(32'h300);
    n = 0;
    guard = 0;
    while (n < 2 && guard < 100) begin
      @(negedge clk);
      if (mif.mem_rvalid) n++;
      guard++;
    end
    check("t6_beats_seen", n, 32'd2);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_re_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_mem_req_after_rst", {31'b0, mif.mem_req}, 32'd0);
    check("t6_valid_after_rst", {31'b0, cache_data_valid}, 32'd1);
    exp_mem(1'b0, 32'h300, 32'h0, 4'b0000);
    exp_op(1'b1, 32'h5A5A_0300, 1'b0, 4);
    drive_load(32'h300);
    wait_done("t6_reload_300");
    exp_op(1'b1, 32'h5A5A_030C, 1'b1, 0);
    drive_load(32'h30C);
    wait_done("t6_hit_30c");
    // A line valid before reset must miss again
    exp_mem(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_op(1'b1, 32'h7700_0011, 1'b0, 4);
    drive_load(32'h100);
    wait_done("t6_reload_100");
    exp_op(1'b1, 32'h0000_CCDD, 1'b1, 0);
    drive_load(32'h108);
    wait_done("t6_hit_108");
    go_idle();
    repeat (3) @(negedge clk);

    check("op_queue_empty", op_q.size(), 32'd0);
    check("mem_queue_empty", mem_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
